// File: rtl/mdr_host_driver.sv
// mdr_host_driver
// Initiator for the MDR operand/handshake protocol. Takes one command
// (op, X, Y) per valid/ready transfer, issues start / op / operand loads to
// the MDR, waits for its result and returns it on a valid/ready response port.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   cmd_*_i / cmd_ready_o command port: op 0 mul, 1 div, 2 root, 3 reserved
//   mdr_*_o               start pulse, op, load pulse, operand bus to the MDR
//   mdr_*_i               load_x / load_y requests, ready, error, result data
//   rsp_*_o / rsp_ready_i response port: result, remainder, error, timeout
//
// state          | meaning
// IDLE           | cmd_ready high, waiting for a command
// START          | one-cycle mdr_start, op presented
// WAIT_X         | waiting for mdr_load_x
// SETUP_X        | X on the bus one cycle ahead of the load pulse
// LOAD_X         | mdr_load high for LOAD_PULSE cycles
// WAIT_Y_OR_RDY  | MDR asks for Y, or (root) reports a result
// SETUP_Y        | Y on the bus one cycle ahead of the load pulse
// LOAD_Y         | mdr_load high for LOAD_PULSE cycles
// WAIT_RDY       | waiting for a fresh rising edge of mdr_ready
// RESP           | response held until rsp_ready
module mdr_host_driver #(
  parameter int DW          = 10,
  parameter int LOAD_PULSE  = 1,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [1:0]    cmd_op_i,
  input  logic [DW-1:0] cmd_x_i,
  input  logic [DW-1:0] cmd_y_i,
  output logic          mdr_start_o,
  output logic [1:0]    mdr_op_o,
  output logic          mdr_load_o,
  output logic [DW-1:0] mdr_data_o,
  input  logic          mdr_load_x_i,
  input  logic          mdr_load_y_i,
  input  logic          mdr_ready_i,
  input  logic          mdr_error_i,
  input  logic [DW-1:0] mdr_result_i,
  input  logic [DW-1:0] mdr_remainder_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_result_o,
  output logic [DW-1:0] rsp_remainder_o,
  output logic          rsp_error_o,
  output logic          rsp_timeout_o
);

  // One counter serves both the wait timeout and the load pulse width.
  localparam int CNT_MAX = (TIMEOUT_CYC > LOAD_PULSE) ? TIMEOUT_CYC : LOAD_PULSE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] LD_LAST = CW'(LOAD_PULSE - 1);

  typedef enum logic [3:0] {
    IDLE, START, WAIT_X, SETUP_X, LOAD_X, WAIT_Y_OR_RDY,
    SETUP_Y, LOAD_Y, WAIT_RDY, RESP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] x_q, y_q;
  logic          rdy_prev_q;
  logic          cmd_ready_q, mdr_start_q, mdr_load_q;
  logic [1:0]    mdr_op_q;
  logic [DW-1:0] mdr_data_q;
  logic          rsp_valid_q, rsp_error_q, rsp_timeout_q;
  logic [DW-1:0] rsp_result_q, rsp_remainder_q;

  logic is_wait, wait_expired, rdy_rise;

  assign is_wait      = (state_q == WAIT_X) || (state_q == WAIT_Y_OR_RDY) ||
                        (state_q == WAIT_RDY);
  // After TIMEOUT_CYC cycles in one wait state the wait is abandoned.
  assign wait_expired = (cnt_q == TO_LAST);
  // Only a fresh 0->1 edge counts, so a ready level left over from the
  // previous operation never produces a capture.
  assign rdy_rise     = mdr_ready_i & ~rdy_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      x_q             <= '0;
      y_q             <= '0;
      rdy_prev_q      <= 1'b0;
      cmd_ready_q     <= 1'b0;
      mdr_start_q     <= 1'b0;
      mdr_load_q      <= 1'b0;
      mdr_op_q        <= 2'd0;
      mdr_data_q      <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_error_q     <= 1'b0;
      rsp_timeout_q   <= 1'b0;
      rsp_result_q    <= '0;
      rsp_remainder_q <= '0;
    end else begin
      rdy_prev_q <= mdr_ready_i;
      cnt_q      <= cnt_q + CW'(1);
      if (is_wait && (mdr_error_i || wait_expired)) begin
        state_q         <= RESP;
        rsp_valid_q     <= 1'b1;
        rsp_error_q     <= 1'b1;
        rsp_timeout_q   <= ~mdr_error_i;
        rsp_result_q    <= '0;
        rsp_remainder_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cmd_ready_q <= 1'b1;
            if (cmd_ready_q && cmd_valid_i) begin
              cmd_ready_q <= 1'b0;
              x_q         <= cmd_x_i;
              y_q         <= cmd_y_i;
              cnt_q       <= '0;
              if (cmd_op_i == 2'd3) begin
                // Reserved op never touches the MDR.
                state_q         <= RESP;
                rsp_valid_q     <= 1'b1;
                rsp_error_q     <= 1'b1;
                rsp_timeout_q   <= 1'b0;
                rsp_result_q    <= '0;
                rsp_remainder_q <= '0;
              end else begin
                state_q     <= START;
                mdr_start_q <= 1'b1;
                mdr_op_q    <= cmd_op_i;
              end
            end
          end
          START: begin
            mdr_start_q <= 1'b0;
            state_q     <= WAIT_X;
            cnt_q       <= '0;
          end
          WAIT_X: if (mdr_load_x_i) begin
            mdr_data_q <= x_q;
            state_q    <= SETUP_X;
            cnt_q      <= '0;
          end
          SETUP_X, SETUP_Y: begin
            mdr_load_q <= 1'b1;
            state_q    <= (state_q == SETUP_X) ? LOAD_X : LOAD_Y;
            cnt_q      <= '0;
          end
          LOAD_X, LOAD_Y: if (cnt_q == LD_LAST) begin
            mdr_load_q <= 1'b0;
            state_q    <= (state_q == LOAD_X) ? WAIT_Y_OR_RDY : WAIT_RDY;
            cnt_q      <= '0;
          end
          WAIT_Y_OR_RDY, WAIT_RDY: begin
            if (state_q == WAIT_Y_OR_RDY && mdr_load_y_i) begin
              mdr_data_q <= y_q;
              state_q    <= SETUP_Y;
              cnt_q      <= '0;
            end else if (rdy_rise) begin
              state_q         <= RESP;
              rsp_valid_q     <= 1'b1;
              rsp_error_q     <= 1'b0;
              rsp_timeout_q   <= 1'b0;
              rsp_result_q    <= mdr_result_i;
              rsp_remainder_q <= mdr_remainder_i;
            end
          end
          RESP: if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            mdr_op_q    <= 2'd0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cmd_ready_o     = cmd_ready_q;
  assign mdr_start_o     = mdr_start_q;
  assign mdr_op_o        = mdr_op_q;
  assign mdr_load_o      = mdr_load_q;
  assign mdr_data_o      = mdr_data_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_result_o    = rsp_result_q;
  assign rsp_remainder_o = rsp_remainder_q;
  assign rsp_error_o     = rsp_error_q;
  assign rsp_timeout_o   = rsp_timeout_q;

endmodule

// File: tb/tb_mdr_host_driver.sv
// tb_mdr_host_driver
// Directed bench for mdr_host_driver with a small behavioural MDR model.
module tb_mdr_host_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [9:0] cmd_x, cmd_y;
  logic       mdr_start, mdr_load;
  logic [1:0] mdr_op;
  logic [9:0] mdr_data;
  logic       mdr_load_x, mdr_load_y, mdr_ready, mdr_error;
  logic [9:0] mdr_result, mdr_remainder;
  logic       rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [9:0] rsp_result, rsp_remainder;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mdr_host_driver #(.DW(10), .LOAD_PULSE(1), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_x_i(cmd_x), .cmd_y_i(cmd_y),
    .mdr_start_o(mdr_start), .mdr_op_o(mdr_op), .mdr_load_o(mdr_load),
    .mdr_data_o(mdr_data),
    .mdr_load_x_i(mdr_load_x), .mdr_load_y_i(mdr_load_y),
    .mdr_ready_i(mdr_ready), .mdr_error_i(mdr_error),
    .mdr_result_i(mdr_result), .mdr_remainder_i(mdr_remainder),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_remainder_o(rsp_remainder),
    .rsp_error_o(rsp_error), .rsp_timeout_o(rsp_timeout)
  );

  // ---------------- MDR model ----------------
  int         m_st, m_dly;
  logic [1:0] m_op;
  logic [9:0] m_x, m_y;
  logic       load_prev;
  bit         stall = 1'b0, keep_ready = 1'b0;
  int         start_cnt = 0, load_cnt = 0;

  function automatic logic [9:0] isqrt(input logic [9:0] v);
    logic [9:0] r = 10'd0;
    for (int k = 1; k < 32; k++) if (k * k <= int'(v)) r = 10'(k);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_st = 0; m_dly = 0; load_prev = 1'b0;
      mdr_load_x = 1'b0; mdr_load_y = 1'b0; mdr_ready = 1'b0; mdr_error = 1'b0;
      mdr_result = 10'd0; mdr_remainder = 10'd0;
    end else begin
      if (mdr_load && !load_prev) load_cnt++;
      load_prev = mdr_load;
      if (mdr_start) begin
        start_cnt++;
        m_op = mdr_op; mdr_error = 1'b0;
        if (!keep_ready) mdr_ready = 1'b0;
        m_st = 1; m_dly = 2;
      end else begin
        case (m_st)
          1: if (m_dly == 0) begin mdr_load_x = 1'b1; m_st = 2; end else m_dly--;
          2: if (mdr_load) begin
               m_x = mdr_data; mdr_load_x = 1'b0;
               m_st = (m_op == 2'd2) ? 5 : 3; m_dly = 2;
             end
          3: if (m_dly == 0) begin mdr_load_y = 1'b1; m_st = 4; end else m_dly--;
          4: if (mdr_load) begin m_y = mdr_data; mdr_load_y = 1'b0; m_st = 5; m_dly = 3; end
          5: if (!stall) begin
               if (m_dly != 0) m_dly--;
               else begin
                 case (m_op)
                   2'd0: begin mdr_result = 10'(m_x * m_y); mdr_remainder = 10'd0; end
                   2'd1: if (m_y == 10'd0) begin
                           mdr_error = 1'b1; mdr_result = 10'h3ff; mdr_remainder = 10'h3ff;
                         end else begin
                           mdr_result = m_x / m_y; mdr_remainder = m_x % m_y;
                         end
                   default: begin mdr_result = isqrt(m_x); mdr_remainder = 10'(m_x - isqrt(m_x) * isqrt(m_x)); end
                 endcase
                 if (mdr_ready) begin mdr_ready = 1'b0; m_st = 6; end
                 else begin mdr_ready = 1'b1; m_st = 0; end
               end
             end
          6: begin mdr_ready = 1'b1; m_st = 0; end
          default: ;
        endcase
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [9:0] x, input logic [9:0] y);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      compared++; mismatched++;
      $display("FAIL cmd_ready_wait got 0 want 1");
    end
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      compared++; mismatched++;
      $display("FAIL %s_rsp_wait got no rsp_valid want rsp_valid=1", name);
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic check_rsp(input string name, input logic [9:0] res, input logic [9:0] rem,
                           input logic err, input logic to);
    compared++;
    if ({rsp_result, rsp_remainder, rsp_error, rsp_timeout} !== {res, rem, err, to}) begin
      mismatched++;
      $display("FAIL %s got res=%0d rem=%0d err=%b to=%b want res=%0d rem=%0d err=%b to=%b",
               name, rsp_result, rsp_remainder, rsp_error, rsp_timeout, res, rem, err, to);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_x = 10'd0; cmd_y = 10'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({cmd_ready, mdr_start, mdr_op, mdr_load, mdr_data, rsp_valid, rsp_result,
         rsp_remainder, rsp_error, rsp_timeout} !== 38'd0) begin
      mismatched++; $display("FAIL reset_outputs got nonzero want all 0");
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_mul();
    int s0 = start_cnt, l0 = load_cnt;
    send_cmd(2'd0, 10'd13, 10'd7);
    wait_rsp("mul");
    check_rsp("mul_13x7", 10'd91, 10'd0, 1'b0, 1'b0);
    compared++;
    if (start_cnt - s0 != 1 || load_cnt - l0 != 2) begin
      mismatched++; $display("FAIL mul_pulses got start=%0d load=%0d want 1/2", start_cnt - s0, load_cnt - l0);
    end
    ack_rsp();
  endtask

  task automatic test_div();
    send_cmd(2'd1, 10'd115, 10'd7);
    wait_rsp("div");
    check_rsp("div_115_7", 10'd16, 10'd3, 1'b0, 1'b0);
    ack_rsp();
    send_cmd(2'd1, 10'd115, 10'd0);
    wait_rsp("div0");
    check_rsp("div_by_zero", 10'd0, 10'd0, 1'b1, 1'b0);
    ack_rsp();
  endtask

  task automatic test_root();
    int l0 = load_cnt;
    send_cmd(2'd2, 10'd100, 10'd0);
    wait_rsp("root");
    check_rsp("root_100", 10'd10, 10'd0, 1'b0, 1'b0);
    compared++;
    if (load_cnt - l0 != 1) begin mismatched++; $display("FAIL root_loads got %0d want 1", load_cnt - l0); end
    ack_rsp();
  endtask

  task automatic test_reserved();
    int s0 = start_cnt, l0 = load_cnt;
    send_cmd(2'd3, 10'd5, 10'd5);
    compared++;
    if (rsp_valid !== 1'b1) begin mismatched++; $display("FAIL reserved_latency got rsp_valid=%b want 1", rsp_valid); end
    check_rsp("reserved", 10'd0, 10'd0, 1'b1, 1'b0);
    compared++;
    if (start_cnt != s0 || load_cnt != l0) begin
      mismatched++; $display("FAIL reserved_activity got start=%0d load=%0d want 0/0", start_cnt - s0, load_cnt - l0);
    end
    ack_rsp();
  endtask

  // Ready is still high from the previous op; only the fresh edge may capture.
  task automatic test_stale_ready();
    keep_ready = 1'b1;
    send_cmd(2'd0, 10'd9, 10'd9);
    wait_rsp("stale");
    check_rsp("stale_ready_9x9", 10'd81, 10'd0, 1'b0, 1'b0);
    ack_rsp();
    keep_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int   p = 0, w = 0;
    logic lp = 1'b0;
    stall = 1'b1;
    send_cmd(2'd0, 10'd5, 10'd3);
    for (int i = 0; i < 200 && !rsp_valid; i++) begin
      if (mdr_load && !lp) p++;
      if (p == 2 && !mdr_load) w++;
      lp = mdr_load;
      @(negedge clk);
    end
    wait_rsp("timeout");
    check_rsp("timeout_flags", 10'd0, 10'd0, 1'b1, 1'b1);
    compared++;
    if (w != 20) begin mismatched++; $display("FAIL timeout_cycles got %0d want 20", w); end
    ack_rsp();
    stall = 1'b0;
  endtask

  task automatic test_hold();
    send_cmd(2'd0, 10'd6, 10'd7);
    wait_rsp("hold");
    for (int i = 0; i < 5; i++) begin
      compared++;
      if ({rsp_valid, cmd_ready, rsp_result, rsp_error} !== {1'b1, 1'b0, 10'd42, 1'b0}) begin
        mismatched++;
        $display("FAIL hold_cycle%0d got valid=%b ready=%b res=%0d want 1/0/42", i, rsp_valid, cmd_ready, rsp_result);
      end
      @(negedge clk);
    end
    ack_rsp();
    compared++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      mismatched++; $display("FAIL hold_release got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int   p = 0, seen = 0;
    logic lp = 1'b0;
    send_cmd(2'd0, 10'd3, 10'd4);
    for (int i = 0; i < 100 && !(p == 2 && mdr_load); i++) begin
      @(negedge clk);
      if (mdr_load && !lp) p++;
      lp = mdr_load;
    end
    compared++;
    if (!(p == 2 && mdr_load)) begin mismatched++; $display("FAIL midreset_reach got loads=%0d want in LOAD_Y", p); end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({cmd_ready, mdr_start, mdr_op, mdr_load, mdr_data, rsp_valid, rsp_result,
         rsp_remainder, rsp_error, rsp_timeout} !== 38'd0) begin
      mismatched++; $display("FAIL midreset_outputs got nonzero want all 0");
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (rsp_valid) seen++; end
    compared++;
    if (seen != 0 || cmd_ready !== 1'b1) begin
      mismatched++; $display("FAIL midreset_no_rsp got rsp cycles=%0d ready=%b want 0/1", seen, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_root();
    test_reserved();
    test_stale_ready();
    test_timeout();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
